// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver.
// Frame: start(0), 8 data bits LSB-first, optional parity, stop(1).
// Three samples around mid-bit are majority-voted. The frame outcome is
// reported by exactly one one-cycle strobe: Data_Valid, Par_Err or Stop_Err.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Par_Err,
    output logic                  Stop_Err,
    // FSM state for observation: 0=IDLE 1=START 2=DATA 3=PARITY 4=STOP
    output logic [2:0]            dbg_state_o
);

    localparam int BIT_CNT_W = $clog2(DATA_WIDTH);
    localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                  state_q;
    logic [PRESCALE_W-1:0]   edge_cnt_q;
    logic [BIT_CNT_W-1:0]    bit_cnt_q;
    logic [PRESCALE_W-1:0]   presc_q;
    logic                    par_en_q;
    logic                    par_typ_q;
    logic [2:0]              samp_q;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic                    par_bad_q;
    logic [DATA_WIDTH-1:0]   p_data_q;
    logic                    dv_q;
    logic                    pe_q;
    logic                    se_q;

    // Helpers derived from the prescale captured at the start of the frame.
    logic [PRESCALE_W-1:0]   half;
    logic                    last_edge;
    logic                    sample_now;
    logic                    voted;
    logic                    par_exp;

    // Bit timing, mid-bit sampling window, majority vote and parity.
    always_comb begin
        half       = presc_q >> 1;
        last_edge  = (edge_cnt_q == presc_q - ONE);
        sample_now = (edge_cnt_q == half - ONE) ||
                     (edge_cnt_q == half) ||
                     (edge_cnt_q == half + ONE);
        voted      = (samp_q[0] & samp_q[1]) |
                     (samp_q[0] & samp_q[2]) |
                     (samp_q[1] & samp_q[2]);
        // Even parity expects XOR of the data; odd expects its inverse.
        par_exp    = (^shift_q) ^ par_typ_q;
    end

    // Receive FSM with registered outputs; strobes default low every cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            presc_q    <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            samp_q     <= '0;
            shift_q    <= '0;
            par_bad_q  <= 1'b0;
            p_data_q   <= '0;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            se_q       <= 1'b0;
        end else begin
            dv_q <= 1'b0;
            pe_q <= 1'b0;
            se_q <= 1'b0;
            if (state_q == S_IDLE) begin
                edge_cnt_q <= '0;
                bit_cnt_q  <= '0;
                if (!RX_IN) begin
                    // This cycle is edge 0 of the start bit; freeze the frame format.
                    presc_q    <= Prescale;
                    par_en_q   <= PAR_EN;
                    par_typ_q  <= PAR_TYP;
                    par_bad_q  <= 1'b0;
                    edge_cnt_q <= ONE;
                    state_q    <= S_START;
                end
            end else begin
                if (sample_now) begin
                    samp_q <= {samp_q[1:0], RX_IN};
                end
                edge_cnt_q <= last_edge ? '0 : edge_cnt_q + ONE;
                if (last_edge) begin
                    case (state_q)
                        S_START: begin
                            // A high vote means the falling edge was a glitch.
                            state_q <= voted ? S_IDLE : S_DATA;
                        end
                        S_DATA: begin
                            shift_q   <= {voted, shift_q[DATA_WIDTH-1:1]};
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            if (bit_cnt_q == LAST_BIT) begin
                                state_q <= par_en_q ? S_PARITY : S_STOP;
                            end
                        end
                        S_PARITY: begin
                            par_bad_q <= (voted != par_exp);
                            state_q   <= S_STOP;
                        end
                        S_STOP: begin
                            // A bad stop bit outranks a parity error.
                            if (!voted) begin
                                se_q <= 1'b1;
                            end else if (par_en_q && par_bad_q) begin
                                pe_q <= 1'b1;
                            end else begin
                                p_data_q <= shift_q;
                                dv_q     <= 1'b1;
                            end
                            state_q <= S_IDLE;
                        end
                        default: state_q <= S_IDLE;
                    endcase
                end
            end
        end
    end

    assign P_DATA      = p_data_q;
    assign Data_Valid  = dv_q;
    assign Par_Err     = pe_q;
    assign Stop_Err    = se_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frames against a frame-level reference model.
module tb_uart_rx;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Prescale;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       Par_Err;
    logic       Stop_Err;
    logic [2:0] dbg_state;

    int   cyc = 0;
    logic rst_prev = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    // Expected frame outcomes: visible cycle, kind (0 good, 1 parity, 2 stop), byte.
    int         exp_cyc_q[$];
    int         exp_kind_q[$];
    logic [7:0] exp_byte_q[$];
    logic [7:0] exp_pdata = 8'h00;

    uart_rx #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .Par_Err    (Par_Err),
        .Stop_Err   (Stop_Err),
        .dbg_state_o(dbg_state)
    );

    // Clock and cycle counter.
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        cyc      <= cyc + 1;
        rst_prev <= RST;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    // Scoreboard: every cycle compare strobes and P_DATA with the model.
    always @(negedge CLK) begin
        logic [10:0] outs;
        logic [10:0] e;
        if (cyc >= 1) begin
            outs = {Data_Valid, Par_Err, Stop_Err, P_DATA};
            if (rst_prev) begin
                exp_pdata = 8'h00;
                exp_cyc_q.delete();
                exp_kind_q.delete();
                exp_byte_q.delete();
                check("reset_outputs", 32'(outs), 32'h0);
            end else begin
                while (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
                    check("result_overdue", 32'(exp_cyc_q[0]), 32'(cyc));
                    void'(exp_cyc_q.pop_front());
                    void'(exp_kind_q.pop_front());
                    void'(exp_byte_q.pop_front());
                end
                if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
                    case (exp_kind_q[0])
                        0:       e = {3'b100, exp_byte_q[0]};
                        1:       e = {3'b010, exp_pdata};
                        default: e = {3'b001, exp_pdata};
                    endcase
                    check("frame_result", 32'(outs), 32'(e));
                    if (exp_kind_q[0] == 0) exp_pdata = exp_byte_q[0];
                    void'(exp_cyc_q.pop_front());
                    void'(exp_kind_q.pop_front());
                    void'(exp_byte_q.pop_front());
                end else begin
                    check("quiet_outputs", 32'(outs), 32'({3'b000, exp_pdata}));
                end
            end
        end
    end

    // Drive one frame; registers its expected outcome at c0 + nbits*p.
    task automatic send_frame(input logic [7:0] d, input int p, input bit pen, input bit ptyp,
                              input bit bad_par, input bit stop_v, input bit scramble,
                              output int c0);
        logic line [11];
        int   nb;
        bit   par;
        par = (($countones(d) % 2) == 1) ^ ptyp ^ bad_par;
        line[0] = 1'b0;
        for (int i = 0; i < 8; i++) line[i+1] = d[i];
        if (pen) begin
            line[9]  = par;
            line[10] = stop_v;
            nb = 11;
        end else begin
            line[9]  = stop_v;
            line[10] = 1'b1;
            nb = 10;
        end
        c0       = cyc;
        Prescale = 6'(p);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        exp_cyc_q.push_back(c0 + nb * p);
        exp_kind_q.push_back(!stop_v ? 2 : ((pen && bad_par) ? 1 : 0));
        exp_byte_q.push_back(d);
        for (int i = 0; i < nb; i++) begin
            RX_IN = line[i];
            for (int k = 0; k < p; k++) begin
                @(posedge CLK);
                #1;
                if (scramble && i == 0 && k == 0) begin
                    Prescale = 6'($urandom_range(0, 63));
                    PAR_EN   = 1'($urandom_range(0, 1));
                    PAR_TYP  = 1'($urandom_range(0, 1));
                end
            end
        end
        RX_IN = 1'b1;
    endtask

    // Short low pulse from idle; must be rejected and back in IDLE by c0+p.
    task automatic glitch(input int p, input int len);
        Prescale = 6'(p);
        RX_IN = 1'b0;
        for (int k = 0; k < p; k++) begin
            @(posedge CLK);
            #1;
            if (k == 0) check("glitch_start_seen", 32'(dbg_state), 32'd1);
            if (k == len - 1) RX_IN = 1'b1;
        end
        check("glitch_back_idle", 32'(dbg_state), 32'd0);
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Frame aborted by a one-cycle reset in the middle of data bit 3.
    task automatic send_abort(input logic [7:0] d, input int p);
        Prescale = 6'(p);
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        repeat (p) begin @(posedge CLK); #1; end
        for (int i = 0; i < 3; i++) begin
            RX_IN = d[i];
            repeat (p) begin @(posedge CLK); #1; end
        end
        RX_IN = d[3];
        repeat (p / 2) begin @(posedge CLK); #1; end
        RST   = 1'b1;
        RX_IN = 1'b1;
        @(posedge CLK);
        #1;
        check("abort_reset_outputs", 32'({Data_Valid, Par_Err, Stop_Err, P_DATA}), 32'h0);
        check("abort_reset_state", 32'(dbg_state), 32'd0);
        RST = 1'b0;
    endtask

    // Directed plan, then randomized frames, then the summary.
    initial begin
        int c0;
        int c0a;
        int p;
        RST      = 1'b1;
        RX_IN    = 1'b1;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        Prescale = 6'd8;
        repeat (3) begin @(posedge CLK); #1; end
        check("reset_state", 32'(dbg_state), 32'd0);
        RST = 1'b0;
        idle(4);

        // Good frame, even parity, 0xA5 -> result 88 cycles after start.
        send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, c0);
        check("even_good_a5", 32'({Data_Valid, Par_Err, Stop_Err, P_DATA}), 32'({3'b100, 8'hA5}));
        idle(3);

        // Same frame with parity bit flipped.
        send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, c0);
        check("parity_err", 32'({Data_Valid, Par_Err, Stop_Err, P_DATA}), 32'({3'b010, 8'hA5}));
        idle(3);

        // Stop error at P=16, no parity.
        send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c0);
        check("stop_err", 32'({Data_Valid, Par_Err, Stop_Err, P_DATA}), 32'({3'b001, 8'hA5}));
        idle(3);

        // Start glitch of 3 cycles, then a normal frame.
        PAR_EN = 1'b0;
        glitch(8, 3);
        send_frame(8'h96, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, c0);
        check("after_glitch", 32'({Data_Valid, Par_Err, Stop_Err, P_DATA}), 32'({3'b100, 8'h96}));
        idle(2);

        // Back-to-back, odd parity.
        send_frame(8'h00, 8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, c0a);
        check("b2b_first", 32'({Data_Valid, Par_Err, Stop_Err, P_DATA}), 32'({3'b100, 8'h00}));
        send_frame(8'hFF, 8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, c0);
        check("b2b_second", 32'({Data_Valid, Par_Err, Stop_Err, P_DATA}), 32'({3'b100, 8'hFF}));
        check("b2b_gap", 32'(c0 - c0a), 32'd88);
        idle(2);

        // Reset mid-frame, then 0x5A.
        send_abort(8'h5A, 8);
        idle(120);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, c0);
        check("after_reset", 32'({Data_Valid, Par_Err, Stop_Err, P_DATA}), 32'({3'b100, 8'h5A}));
        idle(2);

        // Randomized frames, glitches, prescales and gaps.
        for (int n = 0; n < 60; n++) begin
            p = 2 * $urandom_range(4, 16);
            if ($urandom_range(0, 9) == 0) begin
                glitch(p, $urandom_range(1, p / 2 - 1));
            end else begin
                send_frame(8'($urandom_range(0, 255)), p, 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
                           ($urandom_range(0, 5) != 0), 1'b1, c0);
            end
            idle($urandom_range(0, 3));
        end

        idle(5);
        check("queue_drained", 32'(exp_cyc_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
